fp_expand: RTL and testbench
============================

// Module: fp_expand
// PURPOSE
//  Downstream consumer of the 13-bit-to-floating-point converter. Accepts one
//  {S,E,F} word (value = (-1)^S * F * 2^E) over a valid/ready handshake and
//  expands it back to 13-bit two's complement with a serial shifter.
//  The shifter takes one shift per exponent step.
//  Used to display and check converted samples, and to close the loop in system tests.
// PARAMETERS
//  EXP_W   3   exponent width; shift count range is 0..2^EXP_W-1
//  MANT_W  5   significand width
//  OUT_W   13  output width; must satisfy OUT_W >= MANT_W + 2^EXP_W
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst_n      in   1       synchronous reset, active low
//  in_valid   in   1       upstream word present on S/E/F
//  in_ready   out  1       block can accept a word (high only in IDLE)
//  S          in   1       sign, 1 = negative
//  E          in   EXP_W   exponent
//  F          in   MANT_W  significand (unsigned, no hidden bit)
//  out_valid  out  1       D_out holds a finished result
//  out_ready  in   1       downstream accepts D_out
//  D_out      out  OUT_W   two's complement result
//  busy       out  1       high in SHIFT or SIGN
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, acc=0, cnt=0, sign=0.
//   Outputs after reset: in_ready=1, out_valid=0, D_out=0, busy=0.
//   Reset overrides every other event, in any state.
//  FSM states are IDLE, SHIFT, SIGN and DONE.
//  IDLE: in_ready=1.
//   On in_valid&in_ready: acc <= zero-extended F, cnt <= E, sign <= S.
//   Next state is SHIFT if E!=0, else SIGN.
//   Without in_valid, stay in IDLE.
//  SHIFT: acc <= acc<<1 and cnt <= cnt-1.
//   Leave for SIGN on the edge where cnt==1.
//   Exactly E shifts occur.
//  SIGN: if sign, acc <= ~acc+1; else acc is unchanged. Next state is DONE.
//  DONE: out_valid=1 and D_out=acc, both stable until the handshake.
//   On out_ready: next state is IDLE, and out_valid drops on that edge.
//  Latency: out_valid rises E+2 cycles after the accept edge.
//   Throughput is one word per E+3 cycles at best; no overlap, no input buffer.
//  in_valid outside IDLE is ignored; the word is not captured.
//   Upstream must hold the word until it sees in_ready.
//  D_out is a registered copy of acc; it updates only on entry to DONE.
//   It holds its last value in IDLE, SHIFT and SIGN (0 after reset).
//  Arithmetic: the largest magnitude is (2^MANT_W-1)*2^(2^EXP_W-1) = 3968.
//   This fits in OUT_W signed, so there is no overflow or saturation logic.
//  S=1 with F=0 gives D_out=0; negating zero stays zero.
//  -4096 cannot be represented. Its encoding (S=1,E=7,F=31) gives -3968.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clks -> in_ready=1, out_valid=0, busy=0, D_out=0.
//  2 S=0,E=0,F=5, out_ready=1 -> out_valid 2 clks after accept.
//    D_out=13'd5; back in IDLE the next clk.
//  3 S=0,E=7,F=31 -> out_valid 9 clks after accept, D_out=13'd3968.
//  4 S=1,E=3,F=13 -> out_valid 5 clks after accept, D_out=13'b1_1111_1001_1000 (-104).
//    Also S=1,E=2,F=0 gives D_out=0.
//  5 Backpressure: out_ready=0 for 5 clks after out_valid.
//    D_out stays stable and in_ready=0; in_valid pulses with other data are not captured.
//    Then out_ready=1 for 1 clk -> IDLE and in_ready=1.
//  6 Reset mid-SHIFT: start E=6, drop rst_n at the 3rd SHIFT clk -> IDLE next edge.
//    out_valid never asserts; a following E=1,F=1 gives D_out=2.

Source files
------------

// File: rtl/fp_expand.sv
// Expands a {S,E,F} floating-point word back to OUT_W-bit two's complement
// using a serial left shifter (one exponent step per clock), then optional negation.
module fp_expand #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 5,
  parameter int OUT_W  = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [MANT_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [OUT_W-1:0]   acc_reg, acc_next;
  logic [OUT_W-1:0]   d_out_reg, d_out_next;
  logic [EXP_W-1:0]   cnt_reg, cnt_next;
  logic               sign_reg, sign_next;
  logic [OUT_W-1:0]   f_ext;

  // Zero-extend the significand to the accumulator width.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_f_ext
      if (gi < MANT_W) begin : g_bit
        assign f_ext[gi] = F[gi];
      end else begin : g_zero
        assign f_ext[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      d_out_reg <= '0;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      d_out_reg <= d_out_next;
      cnt_reg   <= cnt_next;
      sign_reg  <= sign_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    d_out_next = d_out_reg;
    cnt_next   = cnt_reg;
    sign_next  = sign_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next   = f_ext;
          cnt_next   = E;
          sign_next  = S;
          state_next = (E != '0) ? SHIFT : SIGN;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        acc_next = {acc_reg[OUT_W-2:0], 1'b0};
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == EXP_W'(1)) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        busy = 1'b1;
        if (sign_reg) begin
          acc_next = ~acc_reg + OUT_W'(1);
        end
        // Result register is loaded with the final value as DONE is entered.
        d_out_next = acc_next;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign D_out = d_out_reg;

endmodule

// File: tb/tb_fp_expand.sv
// Self-checking bench for fp_expand: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level timing model.
module tb_fp_expand;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [4:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] D_out;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  fp_expand #(.EXP_W(3), .MANT_W(5), .OUT_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .D_out(D_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a word accepted at an edge yields its result after E+1 more
  // edges (E+2 counting the accept edge) and is held until out_ready is seen.
  bit          m_pending = 1'b0;
  int          m_elapsed = 0;
  int          m_e = 0;
  logic [12:0] m_val = '0;
  logic [12:0] m_dout = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_dout    = '0;
    end else if (!m_pending) begin
      if (in_valid) begin
        int v;
        v = int'(F) * (1 << int'(E));
        if (S) v = -v;
        m_val     = v[12:0];
        m_e       = int'(E);
        m_elapsed = 0;
        m_pending = 1'b1;
      end
    end else if (m_elapsed < m_e + 1) begin
      m_elapsed++;
      if (m_elapsed == m_e + 1) m_dout = m_val;
    end else if (out_ready) begin
      m_pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_in_ready",  13'(in_ready),  13'(!m_pending));
      chk("cyc_out_valid", 13'(out_valid), 13'(m_pending && m_elapsed == m_e + 1));
      chk("cyc_busy",      13'(busy),      13'(m_pending && m_elapsed < m_e + 1));
      chk("cyc_d_out",     D_out,          m_dout);
    end
  end

  // Sends one word from IDLE, checks latency and result; optional backpressure.
  task automatic send_word(input logic s, input logic [2:0] e, input logic [4:0] f,
                           input int exp_lat, input logic [12:0] exp_d, input int hold);
    int lat;
    @(negedge clk);
    S = s; E = e; F = f; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 13'(lat), 13'(exp_lat));
    chk("result", D_out, exp_d);
    $display("[TB] word S=%0d E=%0d F=%0d -> D_out=%0h latency=%0d", s, e, f, D_out, lat);
    for (int i = 0; i < hold; i++) begin
      chk("hold_d_out", D_out, exp_d);
      chk("hold_in_ready", 13'(in_ready), 13'd0);
      chk("hold_out_valid", 13'(out_valid), 13'd1);
      S = 1'($urandom); E = 3'($urandom); F = 5'($urandom);
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", 13'(in_ready), 13'd1);
    chk("post_out_valid", 13'(out_valid), 13'd0);
    chk("post_d_out", D_out, exp_d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    S = 1'b0; E = '0; F = '0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 13'(in_ready), 13'd1);
    chk("rst_out_valid", 13'(out_valid), 13'd0);
    chk("rst_busy", 13'(busy), 13'd0);
    chk("rst_d_out", D_out, 13'd0);
    rst_n = 1'b1;

    send_word(1'b0, 3'd0, 5'd5,  2, 13'd5,    0);
    send_word(1'b0, 3'd7, 5'd31, 9, 13'd3968, 0);
    send_word(1'b1, 3'd3, 5'd13, 5, 13'h1F98, 0);
    send_word(1'b1, 3'd2, 5'd0,  4, 13'd0,    0);
    send_word(1'b1, 3'd7, 5'd31, 9, 13'h1080, 0);
    send_word(1'b1, 3'd4, 5'd9,  6, 13'h1F70, 5);

    // Reset in the middle of a long shift.
    @(negedge clk);
    S = 1'b0; E = 3'd6; F = 5'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 13'(in_ready), 13'd1);
    chk("midrst_busy", 13'(busy), 13'd0);
    chk("midrst_out_valid", 13'(out_valid), 13'd0);
    rst_n = 1'b1;
    send_word(1'b0, 3'd1, 5'd1, 3, 13'd2, 0);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      S = 1'($urandom); E = 3'($urandom); F = 5'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_in_ready", 13'(in_ready), 13'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
